mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : mem_arbiter                                                |
// | Brief    : Two-port (instruction fetch / data) arbiter in front of a  |
// |            single-port synchronous SRAM with 1-cycle read latency.    |
// |            D wins by default; I wins once it has been denied          |
// |            STARVE_MAX consecutive cycles.                             |
// |            Define MEM_ARB_PERF_EN to build the performance counters.  |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       perf_i_cnt,
  output logic [15:0]       perf_d_cnt,
  output logic [15:0]       perf_conf_cnt
);

  // Starvation counter only needs to reach STARVE_MAX.
  localparam int              c_sw         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [c_sw-1:0] c_starve_max = c_sw'(STARVE_MAX);

  // Owner tag of the read whose data returns this cycle.
  localparam logic [1:0] c_own_none = 2'd0;
  localparam logic [1:0] c_own_i    = 2'd1;
  localparam logic [1:0] c_own_d    = 2'd2;

  logic [1:0]      r_owner;
  logic [c_sw-1:0] r_starve;
  logic            w_starved;
  logic            w_i_gnt;
  logic            w_d_gnt;

  // Grants are purely combinational and forced off while reset is held.
  assign w_starved = (r_starve == c_starve_max);
  assign w_i_gnt   = ~reset & i_req & (~d_req | w_starved);
  assign w_d_gnt   = ~reset & d_req & ~w_i_gnt;
  assign i_gnt     = w_i_gnt;
  assign d_gnt     = w_d_gnt;

  // Steer the granted port onto the SRAM; idle bus is all zeros.
  always_comb begin
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_i_gnt) begin
      mem_cs   = 1'b1;
      mem_addr = i_addr;
    end else if (w_d_gnt) begin
      mem_cs    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  // Record who owns the SRAM read data returning next cycle; writes own nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner <= c_own_none;
    end else if (w_i_gnt) begin
      r_owner <= c_own_i;
    end else if (w_d_gnt && !d_we) begin
      r_owner <= c_own_d;
    end else begin
      r_owner <= c_own_none;
    end
  end

  // Count consecutive cycles in which a pending fetch was denied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve <= '0;
    end else if (i_req && !w_i_gnt) begin
      if (!w_starved) begin
        r_starve <= r_starve + c_sw'(1);
      end
    end else begin
      r_starve <= '0;
    end
  end

  // Return path: the non-owner port reads zero.
  assign i_rvalid = (r_owner == c_own_i);
  assign d_rvalid = (r_owner == c_own_d);
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

`ifdef MEM_ARB_PERF_EN
  logic [15:0] r_perf_i;
  logic [15:0] r_perf_d;
  logic [15:0] r_perf_conf;

  // Saturating grant and conflict counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_i    <= '0;
      r_perf_d    <= '0;
      r_perf_conf <= '0;
    end else begin
      if (w_i_gnt && (r_perf_i != 16'hFFFF)) begin
        r_perf_i <= r_perf_i + 16'd1;
      end
      if (w_d_gnt && (r_perf_d != 16'hFFFF)) begin
        r_perf_d <= r_perf_d + 16'd1;
      end
      if (i_req && d_req && (r_perf_conf != 16'hFFFF)) begin
        r_perf_conf <= r_perf_conf + 16'd1;
      end
    end
  end

  assign perf_i_cnt    = r_perf_i;
  assign perf_d_cnt    = r_perf_d;
  assign perf_conf_cnt = r_perf_conf;
`else
  assign perf_i_cnt    = 16'd0;
  assign perf_d_cnt    = 16'd0;
  assign perf_conf_cnt = 16'd0;
`endif

endmodule
`default_nettype wire
